// File: rtl/mem_port_scheduler.sv
// Arbitrates the single data-RAM port between a scalar requester and a VLEN-word
// vector burst requester; round-robin on ties, synchronous-read RAM with 1-cycle latency.
module mem_port_scheduler #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int VLEN   = 18,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_ack,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [DATA_W-1:0] v_wdata,
  output logic [IDX_W-1:0]  v_idx,
  output logic              v_rvalid,
  output logic [IDX_W-1:0]  v_ridx,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, S_ISSUE, V_ISSUE, DRAIN} state_t;
  typedef enum logic {GRANT_SCAL, GRANT_VEC} grant_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  state_t              state;
  grant_t              last_grant;
  logic                op_we;
  logic [DATA_W-1:0]   s_wdata_q;
  logic                pick_vec;
  logic                pick_we;

  // Vector wins a tie only when the scalar side was granted last.
  assign pick_vec = v_req && (!s_req || (last_grant == GRANT_SCAL));
  assign pick_we  = pick_vec ? v_we : s_we;

  // Read data is the RAM output passed straight through; it lands in the cycle
  // the registered s_ack / v_rvalid are high.
  assign s_rdata   = mem_rdata;
  assign v_rdata   = mem_rdata;
  assign mem_wdata = (state == V_ISSUE) ? v_wdata : s_wdata_q;
  assign busy      = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking assignments would make update order matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_VEC;
      op_we      <= 1'b0;
      s_wdata_q  <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      s_ack      <= 1'b0;
      v_done     <= 1'b0;
      v_rvalid   <= 1'b0;
      v_idx      <= '0;
      v_ridx     <= '0;
    end else begin
      s_ack    <= 1'b0;
      v_done   <= 1'b0;
      v_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_req || v_req) begin
            last_grant <= pick_vec ? GRANT_VEC : GRANT_SCAL;
            op_we      <= pick_we;
            s_wdata_q  <= s_wdata;
            mem_addr   <= pick_vec ? v_base : s_addr;
            mem_re     <= !pick_we;
            mem_we     <= pick_we;
            v_idx      <= '0;
            state      <= pick_vec ? V_ISSUE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          s_ack  <= 1'b1;
          state  <= DRAIN;
        end
        V_ISSUE: begin
          // Data for the element issued this cycle returns next cycle.
          v_rvalid <= !op_we;
          v_ridx   <= v_idx;
          if (v_idx == LAST_IDX) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            v_done <= 1'b1;
            state  <= DRAIN;
          end else begin
            v_idx    <= v_idx + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler with a behavioural synchronous-read RAM.
module tb_mem_port_scheduler;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int VLEN   = 18;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_req = 1'b0, s_we = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;
  logic              v_req = 1'b0, v_we = 1'b0;
  logic [ADDR_W-1:0] v_base = '0;
  logic [DATA_W-1:0] v_wdata;
  logic [IDX_W-1:0]  v_idx, v_ridx;
  logic              v_rvalid, v_done;
  logic [DATA_W-1:0] v_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0, failures = 0;
  int sack_cnt = 0, vdone_cnt = 0, overlap_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  assign v_wdata = 32'(v_idx) * 32'd3;

  mem_port_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VLEN(VLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_wdata(v_wdata),
    .v_idx(v_idx), .v_rvalid(v_rvalid), .v_ridx(v_ridx), .v_rdata(v_rdata), .v_done(v_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_re && mem_we) overlap_cnt++;
    if (s_ack) sack_cnt++;
    if (v_done) vdone_cnt++;
    if (s_ack && v_done) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_scalar(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd,
                           output logic ok);
    ok = 1'b0; rd = '0;
    s_req = 1'b1; s_we = we; s_addr = a; s_wdata = d;
    for (int k = 0; k < 10 && !ok; k++) begin
      tick();
      if (s_ack) begin ok = 1'b1; rd = s_rdata; end
    end
    s_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_addr, mem_re, mem_we, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mem: addr=%h re=%b we=%b busy=%b, required all 0", mem_addr, mem_re, mem_we, busy);
    end
    checks++;
    if ({s_ack, v_done, v_rvalid, v_idx, v_ridx} !== '0) begin
      failures++;
      $display("FAIL reset_hs: s_ack=%b v_done=%b v_rvalid=%b v_idx=%0d v_ridx=%0d, required all 0",
               s_ack, v_done, v_rvalid, v_idx, v_ridx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_scalar_read();
    preload(19'h00010, 32'hDEADBEEF);
    s_req = 1'b1; s_we = 1'b0; s_addr = 19'h00010;
    tick();
    s_addr = 19'h00055;
    checks++;
    if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === 19'h00010 && busy === 1'b1)) begin
      failures++;
      $display("FAIL sread_issue: re=%b we=%b addr=%h busy=%b, required re=1 we=0 addr=00010 busy=1",
               mem_re, mem_we, mem_addr, busy);
    end
    tick();
    checks++;
    if (!(s_ack === 1'b1 && s_rdata === 32'hDEADBEEF && mem_re === 1'b0)) begin
      failures++;
      $display("FAIL sread_ack: ack=%b rdata=%h re=%b, required ack=1 rdata=deadbeef re=0", s_ack, s_rdata, mem_re);
    end
    s_req = 1'b0;
    tick();
    checks++;
    if (!(busy === 1'b0 && s_ack === 1'b0)) begin
      failures++;
      $display("FAIL sread_idle: busy=%b ack=%b, required 0 0", busy, s_ack);
    end
  endtask

  task automatic test_vector_write();
    int vd0;
    vd0 = vdone_cnt;
    v_req = 1'b1; v_we = 1'b1; v_base = 19'h00100;
    tick();
    for (int i = 0; i < VLEN; i++) begin
      if (i == 5) v_base = 19'h00000;
      checks++;
      if (!(mem_we === 1'b1 && mem_re === 1'b0 && mem_addr === 19'(32'h100 + i) &&
            mem_wdata === 32'(i * 3) && v_idx === IDX_W'(i) && v_done === 1'b0)) begin
        failures++;
        $display("FAIL vwrite_elem%0d: we=%b re=%b addr=%h data=%0d idx=%0d done=%b, required we=1 re=0 addr=%h data=%0d idx=%0d done=0",
                 i, mem_we, mem_re, mem_addr, mem_wdata, v_idx, v_done, 19'(32'h100 + i), i * 3, i);
      end
      tick();
    end
    checks++;
    if (!(v_done === 1'b1 && mem_we === 1'b0 && mem_re === 1'b0 && v_rvalid === 1'b0)) begin
      failures++;
      $display("FAIL vwrite_done: done=%b we=%b re=%b rvalid=%b, required 1 0 0 0", v_done, mem_we, mem_re, v_rvalid);
    end
    v_req = 1'b0;
    tick();
    checks++;
    if (!(busy === 1'b0 && vdone_cnt == vd0 + 1)) begin
      failures++;
      $display("FAIL vwrite_end: busy=%b done_pulses=%0d, required busy=0 pulses=1", busy, vdone_cnt - vd0);
    end
    checks++;
    if (!(ram[19'h00111] === 32'd51 && ram[19'h0010A] === 32'd30)) begin
      failures++;
      $display("FAIL vwrite_ram: ram[111]=%0d ram[10a]=%0d, required 51 30", ram[19'h00111], ram[19'h0010A]);
    end
  endtask

  task automatic test_vector_read_wrap();
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < VLEN; k++) begin
      a = 19'h7FFF8 + 19'(k);
      preload(a, 32'hA5A50000 | 32'(k));
    end
    v_req = 1'b1; v_we = 1'b0; v_base = 19'h7FFF8;
    tick();
    for (int i = 0; i < VLEN; i++) begin
      a = 19'h7FFF8 + 19'(i);
      checks++;
      if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === a && v_idx === IDX_W'(i))) begin
        failures++;
        $display("FAIL vread_addr%0d: re=%b we=%b addr=%h idx=%0d, required re=1 we=0 addr=%h idx=%0d",
                 i, mem_re, mem_we, mem_addr, v_idx, a, i);
      end
      checks++;
      if (i == 0) begin
        if (v_rvalid !== 1'b0) begin
          failures++;
          $display("FAIL vread_rv0: rvalid=%b, required 0", v_rvalid);
        end
      end else if (!(v_rvalid === 1'b1 && v_ridx === IDX_W'(i - 1) && v_rdata === (32'hA5A50000 | 32'(i - 1)))) begin
        failures++;
        $display("FAIL vread_data%0d: rvalid=%b ridx=%0d rdata=%h, required 1 %0d %h",
                 i, v_rvalid, v_ridx, v_rdata, i - 1, 32'hA5A50000 | 32'(i - 1));
      end
      tick();
    end
    checks++;
    if (!(v_done === 1'b1 && v_rvalid === 1'b1 && v_ridx === IDX_W'(17) && v_rdata === 32'hA5A50011 && mem_re === 1'b0)) begin
      failures++;
      $display("FAIL vread_last: done=%b rvalid=%b ridx=%0d rdata=%h re=%b, required 1 1 17 a5a50011 0",
               v_done, v_rvalid, v_ridx, v_rdata, mem_re);
    end
    v_req = 1'b0;
    tick();
    checks++;
    if (!(v_rvalid === 1'b0 && busy === 1'b0)) begin
      failures++;
      $display("FAIL vread_end: rvalid=%b busy=%b, required 0 0", v_rvalid, busy);
    end
  endtask

  task automatic test_arbitration();
    logic got_vec, seen;
    rst = 1'b1; tick(); rst = 1'b0;
    s_we = 1'b0; s_addr = 19'h00010; v_we = 1'b0; v_base = 19'h00300;
    s_req = 1'b1; v_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      seen = 1'b0; got_vec = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        tick();
        if (s_ack || v_done) begin seen = 1'b1; got_vec = v_done; end
      end
      if (r == 3) begin s_req = 1'b0; v_req = 1'b0; end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL arb_round%0d: no ack within 40 cycles, required one", r);
      end else if (got_vec !== r[0]) begin
        failures++;
        $display("FAIL arb_round%0d: granted vec=%b, required vec=%b", r, got_vec, r[0]);
      end
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL arb_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int vd0;
    logic [DATA_W-1:0] rd;
    logic ok;
    v_req = 1'b1; v_we = 1'b1; v_base = 19'h00200;
    tick();
    repeat (7) tick();
    checks++;
    if (!(v_idx === IDX_W'(7) && mem_we === 1'b1 && mem_addr === 19'h00207)) begin
      failures++;
      $display("FAIL rmid_pre: idx=%0d we=%b addr=%h, required 7 1 00207", v_idx, mem_we, mem_addr);
    end
    vd0 = vdone_cnt;
    rst = 1'b1;
    tick();
    checks++;
    if (!(mem_we === 1'b0 && busy === 1'b0 && v_done === 1'b0 && v_idx === '0)) begin
      failures++;
      $display("FAIL rmid_abort: we=%b busy=%b done=%b idx=%0d, required 0 0 0 0", mem_we, busy, v_done, v_idx);
    end
    rst = 1'b0; v_req = 1'b0;
    tick(); tick();
    checks++;
    if (!(vdone_cnt == vd0 && ram[19'h00206] === 32'd18)) begin
      failures++;
      $display("FAIL rmid_after: done_pulses=%0d ram[206]=%0d, required 0 18", vdone_cnt - vd0, ram[19'h00206]);
    end
    do_scalar(1'b0, 19'h00203, 32'h0, rd, ok);
    checks++;
    if (!(ok === 1'b1 && rd === 32'd9)) begin
      failures++;
      $display("FAIL rmid_scalar: ack=%b rdata=%0d, required 1 9", ok, rd);
    end
  endtask

  task automatic test_back_to_back();
    int sa0, ov0;
    sa0 = sack_cnt; ov0 = overlap_cnt;
    s_req = 1'b1; s_we = 1'b1; s_addr = 19'h00040; s_wdata = 32'h00001234;
    tick();
    s_we = 1'b0;
    checks++;
    if (!(mem_we === 1'b1 && mem_re === 1'b0 && mem_addr === 19'h00040 && mem_wdata === 32'h00001234)) begin
      failures++;
      $display("FAIL b2b_write: we=%b re=%b addr=%h data=%h, required 1 0 00040 00001234", mem_we, mem_re, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (s_ack !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack1: ack=%b, required 1", s_ack);
    end
    tick();
    checks++;
    if (!(s_ack === 1'b0 && busy === 1'b0)) begin
      failures++;
      $display("FAIL b2b_gap: ack=%b busy=%b, required 0 0", s_ack, busy);
    end
    tick();
    checks++;
    if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === 19'h00040)) begin
      failures++;
      $display("FAIL b2b_read: re=%b we=%b addr=%h, required 1 0 00040", mem_re, mem_we, mem_addr);
    end
    tick();
    checks++;
    if (!(s_ack === 1'b1 && s_rdata === 32'h00001234)) begin
      failures++;
      $display("FAIL b2b_ack2: ack=%b rdata=%h, required 1 00001234", s_ack, s_rdata);
    end
    s_req = 1'b0;
    tick(); tick();
    checks++;
    if (!(sack_cnt == sa0 + 2 && overlap_cnt == ov0 && busy === 1'b0)) begin
      failures++;
      $display("FAIL b2b_count: ack_pulses=%0d overlaps=%0d busy=%b, required 2 0 0", sack_cnt - sa0, overlap_cnt - ov0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_scalar_read();
    test_vector_write();
    test_vector_read_wrap();
    test_arbitration();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (!(overlap_cnt == 0 && both_cnt == 0)) begin
      failures++;
      $display("FAIL global_excl: re_we_overlaps=%0d dual_acks=%0d, required 0 0", overlap_cnt, both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
